// File: rtl/alu_ctl_pkg.sv
// Shared encodings for the registered ALU control generator.
// ALUCTL_MULDIV_EN adds the ITER/COMMIT states used by MULT/DIVU sequencing.
package alu_ctl_pkg;

    localparam logic [3:0] CTL_AND     = 4'b0000;
    localparam logic [3:0] CTL_OR      = 4'b0001;
    localparam logic [3:0] CTL_ADD     = 4'b0010;
    localparam logic [3:0] CTL_MSTEP   = 4'b0011;
    localparam logic [3:0] CTL_DSTEP   = 4'b0100;
    localparam logic [3:0] CTL_COMMIT  = 4'b0101;
    localparam logic [3:0] CTL_SUB     = 4'b0110;
    localparam logic [3:0] CTL_SLT     = 4'b0111;
    localparam logic [3:0] CTL_LUI     = 4'b1000;
    localparam logic [3:0] CTL_NOR     = 4'b1100;
    localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } alu_op_e;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIVU = 6'b011011;

    localparam logic [2:0] IOP_AND = 3'b100;
    localparam logic [2:0] IOP_OR  = 3'b101;
    localparam logic [2:0] IOP_SLT = 3'b010;
    localparam logic [2:0] IOP_LUI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef ALUCTL_MULDIV_EN
        ST_ITER   = 2'd2,
        ST_COMMIT = 2'd3,
`endif
        ST_EMIT   = 2'd1
    } state_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational {alu_op, func_code} decoder; MULT/DIVU are flagged only
// when ALUCTL_MULDIV_EN is defined, otherwise they decode as illegal.
module alu_ctl_decode
    import alu_ctl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] func_code,
    output logic [3:0] code,
    output logic       illegal,
    output logic       is_mul,
    output logic       is_div
);

    always_comb begin
        code    = CTL_ILLEGAL;
        illegal = 1'b1;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (alu_op)
            ALUOP_ADD: begin code = CTL_ADD; illegal = 1'b0; end
            ALUOP_SUB: begin code = CTL_SUB; illegal = 1'b0; end
            ALUOP_RTYPE: begin
                case (func_code)
                    FN_ADD: begin code = CTL_ADD; illegal = 1'b0; end
                    FN_SUB: begin code = CTL_SUB; illegal = 1'b0; end
                    FN_AND: begin code = CTL_AND; illegal = 1'b0; end
                    FN_OR:  begin code = CTL_OR;  illegal = 1'b0; end
                    FN_NOR: begin code = CTL_NOR; illegal = 1'b0; end
                    FN_SLT: begin code = CTL_SLT; illegal = 1'b0; end
`ifdef ALUCTL_MULDIV_EN
                    FN_MULT: begin code = CTL_MSTEP; illegal = 1'b0; is_mul = 1'b1; end
                    FN_DIVU: begin code = CTL_DSTEP; illegal = 1'b0; is_div = 1'b1; end
`endif
                    default: ;
                endcase
            end
            default: begin
                case (func_code[2:0])
                    IOP_AND: begin code = CTL_AND; illegal = 1'b0; end
                    IOP_OR:  begin code = CTL_OR;  illegal = 1'b0; end
                    IOP_SLT: begin code = CTL_SLT; illegal = 1'b0; end
                    IOP_LUI: begin code = CTL_LUI; illegal = 1'b0; end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered, handshaked ALU control generator with optional MULT/DIVU
// step sequencing (enabled by defining ALUCTL_MULDIV_EN).
module alu_control_seq
    import alu_ctl_pkg::*;
#(
    parameter int CTL_W = 4,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTL_W-1:0] alu_ctl,
    output logic             out_last,
    output logic             illegal
);

    logic [3:0] dec_code;
    logic       dec_illegal;
    logic       dec_is_mul;
    logic       dec_is_div;

    alu_ctl_decode u_decode (
        .alu_op    (alu_op),
        .func_code (func_code),
        .code      (dec_code),
        .illegal   (dec_illegal),
        .is_mul    (dec_is_mul),
        .is_div    (dec_is_div)
    );

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [CTL_W-1:0] alu_ctl_q, alu_ctl_d;
    logic             out_last_q, out_last_d;
    logic             illegal_q, illegal_d;
    logic             take, accept;

`ifdef ALUCTL_MULDIV_EN
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_muldiv;
    assign unused_muldiv = dec_is_mul | dec_is_div;
`endif

    assign in_ready = !out_valid_q || (out_ready && out_last_q);
    assign take     = out_valid_q && out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_ctl_d   = alu_ctl_q;
        out_last_d  = out_last_q;
        illegal_d   = illegal_q;
`ifdef ALUCTL_MULDIV_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
`ifdef ALUCTL_MULDIV_EN
            ST_ITER: begin
                if (take) begin
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d    = ST_COMMIT;
                        alu_ctl_d  = CTL_W'(CTL_COMMIT);
                        out_last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            // IDLE, EMIT and COMMIT share one rule: the last beat is out (or none
            // is pending), so an accepted request loads directly with no bubble.
            default: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    illegal_d   = dec_illegal;
                    alu_ctl_d   = CTL_W'(dec_code);
                    state_d     = ST_EMIT;
                    out_last_d  = 1'b1;
`ifdef ALUCTL_MULDIV_EN
                    if (dec_is_mul || dec_is_div) begin
                        state_d    = ST_ITER;
                        cnt_d      = '0;
                        out_last_d = 1'b0;
                    end
`endif
                end else if (take) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_ctl_q   <= '0;
            out_last_q  <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALUCTL_MULDIV_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_ctl_q   <= alu_ctl_d;
            out_last_q  <= out_last_d;
            illegal_q   <= illegal_d;
`ifdef ALUCTL_MULDIV_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign alu_ctl   = alu_ctl_q;
    assign out_last  = out_last_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench: directed plus random requests scored against a
// queue of expected beats built from the decode rules.
module tb_alu_control_seq;

    localparam int TB_ITER = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_op;
    logic [5:0] func_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_ctl;
    logic       out_last;
    logic       illegal;

    alu_control_seq #(.CTL_W(4), .ITER(TB_ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .func_code (func_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctl   (alu_ctl),
        .out_last  (out_last),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ctl;
        logic       last;
        logic       ill;
    } beat_t;

    beat_t q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [3:0] c, input logic l, input logic i);
        beat_t b;
        b.ctl = c; b.last = l; b.ill = i;
        return b;
    endfunction

    // Expected beat sequence for one accepted request
    task automatic push_req(input logic [1:0] op, input logic [5:0] fc);
        logic [3:0] c;
        logic       ok;
        c = 4'hF; ok = 1'b0;
`ifdef ALUCTL_MULDIV_EN
        if (op == 2'd2 && (fc == 6'h18 || fc == 6'h1B)) begin
            for (int i = 0; i < TB_ITER; i++)
                q.push_back(mk((fc == 6'h18) ? 4'h3 : 4'h4, 1'b0, 1'b0));
            q.push_back(mk(4'h5, 1'b1, 1'b0));
            return;
        end
`endif
        case (op)
            2'd0: begin c = 4'h2; ok = 1'b1; end
            2'd1: begin c = 4'h6; ok = 1'b1; end
            2'd2: begin
                case (fc)
                    6'h20: begin c = 4'h2; ok = 1'b1; end
                    6'h22: begin c = 4'h6; ok = 1'b1; end
                    6'h24: begin c = 4'h0; ok = 1'b1; end
                    6'h25: begin c = 4'h1; ok = 1'b1; end
                    6'h27: begin c = 4'hC; ok = 1'b1; end
                    6'h2A: begin c = 4'h7; ok = 1'b1; end
                    default: ;
                endcase
            end
            default: begin
                case (fc[2:0])
                    3'd4: begin c = 4'h0; ok = 1'b1; end
                    3'd5: begin c = 4'h1; ok = 1'b1; end
                    3'd2: begin c = 4'h7; ok = 1'b1; end
                    3'd7: begin c = 4'h8; ok = 1'b1; end
                    default: ;
                endcase
            end
        endcase
        q.push_back(mk(ok ? c : 4'hF, 1'b1, !ok));
    endtask

    // One cycle: drive at negedge, check, then apply the handshake to the model
    task automatic step(input logic v, input logic [1:0] op, input logic [5:0] fc, input logic ordy);
        logic ev, er, acc, tk;
        in_valid = v; alu_op = op; func_code = fc; out_ready = ordy;
        #1;
        ev = (q.size() != 0);
        er = (q.size() == 0) || (ordy && q.size() == 1);
        check("out_valid", 32'(out_valid), 32'(ev));
        check("in_ready", 32'(in_ready), 32'(er));
        if (ev) begin
            check("alu_ctl", 32'(alu_ctl), 32'(q[0].ctl));
            check("out_last", 32'(out_last), 32'(q[0].last));
            check("illegal", 32'(illegal), 32'(q[0].ill));
        end
        acc = v && er;
        tk  = ev && ordy;
        @(posedge clk);
        if (tk) void'(q.pop_front());
        if (acc) push_req(op, fc);
        @(negedge clk);
    endtask

    logic [5:0] fn_pool [10];

    initial begin
        fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h18, 6'h1B, 6'h07, 6'h00};
        rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'd0; func_code = 6'd0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_ctl", 32'(alu_ctl), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single SUB beat
        step(1, 2'd2, 6'h22, 1);
        step(0, 2'd0, 6'h00, 1);
        // Back-to-back ADD, AND, SLT, NOR
        step(1, 2'd2, 6'h20, 1);
        step(1, 2'd2, 6'h24, 1);
        step(1, 2'd2, 6'h2A, 1);
        step(1, 2'd2, 6'h27, 1);
        step(0, 2'd0, 6'h00, 1);
        // I-type LUI, then an illegal funct
        step(1, 2'd3, 6'h0F, 1);
        step(1, 2'd2, 6'h07, 1);
        step(0, 2'd0, 6'h00, 1);
        step(0, 2'd0, 6'h00, 1);
        // MULT with toggling out_ready and a pending request held behind it
        step(1, 2'd2, 6'h18, 1);
        for (int i = 0; i < 2 * TB_ITER + 4; i++)
            step(1, 2'd0, 6'h00, (i % 2) == 0);
        step(0, 2'd0, 6'h00, 1);
        step(0, 2'd0, 6'h00, 1);

`ifdef ALUCTL_MULDIV_EN
        // Reset during the third DSTEP beat aborts the sequence
        step(1, 2'd2, 6'h1B, 1);
        step(0, 2'd0, 6'h00, 1);
        step(0, 2'd0, 6'h00, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("dstep3_valid", 32'(out_valid), 32'd1);
        check("dstep3_ctl", 32'(alu_ctl), 32'h4);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 2'd1, 6'h18, 1);
        step(0, 2'd0, 6'h00, 1);
`else
        // MULT without the sequencer is one illegal beat
        step(1, 2'd2, 6'h18, 1);
        step(0, 2'd0, 6'h00, 1);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [5:0] fc;
            fc = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 9)];
            step($urandom_range(0, 3) != 0, 2'($urandom), fc, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < TB_ITER + 4; i++)
            step(0, 2'd0, 6'h00, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, handshaked ALU control generator for the MIPS datapath, replacing the purely combinational ALUOp/funct decoder. It accepts one {ALUOp, funct} request per cycle and emits a registered ALU control word. It adds I-type logical decode and an illegal-funct flag. It also adds iterative MULT/DIVU sequencing: one request expands into ITER step control words followed by a HI/LO commit word. It sits between the main control unit and the ALU/HI-LO datapath, and its busy back-pressure stalls issue.

## Interface
Parameters:
- CTL_W, 4: control word width; must be ≥4; codes are zero-extended.
- ITER, 32: step beats per MULT/DIVU; must be ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- alu_op  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 I-type logical (decode func_code[2:0]).
- func_code  in  6  R-type funct, or opcode low bits when alu_op=11.
- out_valid  out  1  alu_ctl holds a valid beat.
- out_ready  in  1  downstream takes the beat when out_valid && out_ready.
- alu_ctl  out  CTL_W  control word.
- out_last  out  1  final beat of the current request.
- illegal  out  1  current beat came from an undefined encoding.

## Operation
- Codes:
  - AND 0000, OR 0001, ADD 0010, MSTEP 0011, DSTEP 0100, COMMIT 0101, SUB 0110, SLT 0111, LUI 1000, NOR 1100, ILLEGAL 1111.
- alu_op=00 gives ADD; 01 gives SUB. func_code is ignored for both.
- alu_op=10 decodes funct:
  - 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100111 NOR; 101010 SLT.
  - 011000 MULT and 011011 DIVU are multi-cycle.
  - Anything else gives ILLEGAL with illegal=1.
- alu_op=11 decodes func_code[2:0]: 100 AND, 101 OR, 010 SLT, 111 LUI, else ILLEGAL with illegal=1.
- An illegal request is a normal single beat with out_last=1. It never hangs.
- FSM states:
  - IDLE: no beat pending.
  - EMIT: single beat held.
  - ITER: step beats; counter cnt of width $clog2(ITER).
  - COMMIT.
- Transitions:
  - IDLE→EMIT on a single-cycle request.
  - IDLE→ITER on MULT/DIVU, with cnt=0.
  - EMIT→IDLE on accept with no new request; EMIT→EMIT/ITER on accept plus a new request (back-to-back).
  - ITER: each accepted beat increments cnt. On the accepted beat with cnt=ITER-1, go to COMMIT.
  - COMMIT→IDLE, EMIT or ITER on accept, same rules as EMIT.
- ITER outputs MSTEP (MULT) or DSTEP (DIVU) with out_last=0. COMMIT outputs COMMIT with out_last=1.
- in_ready = !out_valid || (out_ready && out_last). It is combinational from registered state and out_ready.
- Outputs are stable while out_valid && !out_ready.
- Reset mid-sequence aborts the operation with no commit beat.

## Timing
- Reset values: out_valid=0, alu_ctl=0, out_last=0, illegal=0, state=IDLE, cnt=0. in_ready=1 after reset.
- Single-cycle op: accepted at edge N gives out_valid at cycle N+1. Sustained throughput is 1/cycle with out_ready held high.
- MULT/DIVU: exactly ITER+1 beats. The first beat is at N+1; the commit beat is at N+1+ITER with no stalls. in_ready is low from N+1 until the commit beat is taken.
- A stall (out_ready=0) freezes cnt and all outputs; no beat is dropped or duplicated.
- Simultaneous last-beat accept and new request: the new beat appears on the next cycle with no bubble.

## Configuration
- ALUCTL_MULDIV_EN defined: MULT/DIVU sequencing as above.
- Not defined:
  - 011000 and 011011 decode as ILLEGAL single beats.
  - ITER, COMMIT and cnt are not built.
  - The ITER parameter is ignored.

## Structure
- Package alu_ctl_pkg holds:
  - the CTL code localparams;
  - the ALUOp and funct encodings;
  - the state enum.
- Sub-module alu_ctl_decode is combinational. It maps {alu_op, func_code} to {code, illegal, is_mul, is_div}. The top keeps the FSM, counter and output registers.

## Test plan
- Reset then alu_op=10, funct=100010, out_ready=1 → after reset all outputs 0 and in_ready=1; one beat 0110 with out_last=1 at the next cycle.
- Back-to-back ADD, AND, SLT, NOR, out_ready=1 → beats 0010, 0000, 0111, 1100 on consecutive cycles.
- alu_op=11, func_code[2:0]=111 → 1000. Then funct 000111 with alu_op=10 → 1111 with illegal=1 and out_last=1, followed by in_ready=1.
- MULT with ITER=4 and out_ready toggling 1,0,1… → exactly four 0011 beats, then 0101 with out_last=1; in_ready=0 throughout; values hold during stalls.
- rst_n pulsed low during the 3rd DSTEP beat → out_valid drops immediately, no COMMIT beat, next request decodes normally.
- Without ALUCTL_MULDIV_EN: funct 011000 → single 1111 beat with illegal=1.
